// File: rtl/vred_accum_unit.sv
// Multi-beat vector reduction engine (sum / min / max, signed or unsigned) with per-element
// masking, lane-wise accumulation across beats, a log-depth lane fold and a scalar seed.
module vred_accum_unit #(
  parameter int DATA_WIDTH    = 64,
  parameter int SEW_WIDTH     = 2,
  parameter int OPSEL_WIDTH   = 3,
  parameter bit ENABLE_64_BIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   scalar_init,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OPSEL_WIDTH-1:0]  opSel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int MAX_SEW   = $clog2(NUM_BYTES);
  localparam int MAX_LANES = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FOLD  = 3'd2,
    SEED  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [DATA_WIDTH-1:0]   acc_r;
  logic [DATA_WIDTH-1:0]   scalar_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic                    out_valid_r;
  logic [1:0]              sew_r;
  logic [2:0]              op_r;
  logic [2:0]              fold_cnt_r;

  logic                    xfer_s;
  logic [1:0]              in_sew_s;
  logic [1:0]              cur_sew_s;
  logic [2:0]              cur_op_s;
  logic [63:0]             beat_s;
  logic [63:0]             accum_s;
  logic [63:0]             fold_s;
  logic [63:0]             seed_s;

  function automatic logic [63:0] width_mask(input logic [1:0] s);
    logic [63:0] m;
    case (s)
      2'd0:    m = 64'h0000_0000_0000_00ff;
      2'd1:    m = 64'h0000_0000_0000_ffff;
      2'd2:    m = 64'h0000_0000_ffff_ffff;
      default: m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

  function automatic int lane_bits(input logic [1:0] s);
    return 32'd8 << s;
  endfunction

  function automatic logic [1:0] eff_sew(input logic [SEW_WIDTH-1:0] s);
    logic [1:0] e;
    e = s[1:0];
    if ((ENABLE_64_BIT == 1'b0) && (e == 2'd3)) begin
      e = 2'd2;
    end else begin
      e = e;
    end
    // Element widths wider than a beat collapse to a single full-width lane.
    if (int'(e) > MAX_SEW) begin
      e = 2'(MAX_SEW);
    end else begin
      e = e;
    end
    return e;
  endfunction

  function automatic logic [63:0] identity(input logic [1:0] s, input logic [2:0] op);
    logic [63:0] m;
    logic [63:0] sb;
    logic [63:0] id;
    m  = width_mask(s);
    sb = m ^ (m >> 1);
    if (!op[2]) begin
      id = 64'd0;
    end else if (!op[1]) begin
      id = op[0] ? 64'd0 : m;
    end else begin
      id = op[0] ? sb : (m ^ sb);
    end
    return id;
  endfunction

  // Single element op at width s; on a tie the first (accumulator) operand wins.
  function automatic logic [63:0] elem_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s, input logic [2:0] op);
    logic [63:0] m;
    logic [63:0] sb;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] ak;
    logic [63:0] bk;
    logic [63:0] r;
    logic        take_b;
    m  = width_mask(s);
    sb = m ^ (m >> 1);
    am = a & m;
    bm = b & m;
    if (op[1]) begin
      ak = am ^ sb;
      bk = bm ^ sb;
    end else begin
      ak = am;
      bk = bm;
    end
    take_b = op[0] ? (bk > ak) : (bk < ak);
    if (!op[2]) begin
      r = (am + bm) & m;
    end else if (take_b) begin
      r = bm;
    end else begin
      r = am;
    end
    return r;
  endfunction

  function automatic logic [63:0] vec_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] s, input logic [2:0] op);
    logic [63:0] m;
    logic [63:0] t;
    logic [63:0] r;
    int          w;
    m = width_mask(s);
    w = lane_bits(s);
    r = 64'd0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < (MAX_LANES >> s)) begin
        t = elem_op((a >> (i * w)) & m, (b >> (i * w)) & m, s, op);
        r = r | (t << (i * w));
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] mask_beat(input logic [63:0] d, input logic [7:0] mk,
                                            input logic [1:0] s, input logic [2:0] op);
    logic [63:0] m;
    logic [63:0] t;
    logic [63:0] r;
    int          w;
    m = width_mask(s);
    w = lane_bits(s);
    r = 64'd0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < (MAX_LANES >> s)) begin
        if ((i < (NUM_BYTES >> s)) && mk[i]) begin
          t = (d >> (i * w)) & m;
        end else begin
          t = identity(s, op);
        end
        r = r | (t << (i * w));
      end
    end
    return r;
  endfunction

  // One fold level: the low half of the live lanes absorbs the high half, the rest go to identity.
  function automatic logic [63:0] fold_step(input logic [63:0] a, input logic [1:0] s,
                                            input logic [2:0] cnt, input logic [2:0] op);
    logic [63:0] m;
    logic [63:0] v;
    logic [63:0] t;
    logic [63:0] r;
    int          w;
    int          half;
    m    = width_mask(s);
    w    = lane_bits(s);
    half = (cnt == 3'd0) ? 0 : int'(32'd1 << (cnt - 3'd1));
    v    = vec_op(a, a >> (half * w), s, op);
    r    = 64'd0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < (MAX_LANES >> s)) begin
        t = (i < half) ? ((v >> (i * w)) & m) : identity(s, op);
        r = r | (t << (i * w));
      end
    end
    return r;
  endfunction

  // Datapath: pick live sew/op (incoming on the first beat, latched afterwards) and build candidates.
  always_comb begin
    xfer_s   = in_valid && in_ready;
    in_sew_s = eff_sew(sew);
    if (state_r == IDLE) begin
      cur_sew_s = in_sew_s;
      cur_op_s  = opSel[2:0];
    end else begin
      cur_sew_s = sew_r;
      cur_op_s  = op_r;
    end
    beat_s  = mask_beat(64'(in_data), 8'(in_mask), cur_sew_s, cur_op_s);
    accum_s = vec_op(64'(acc_r), beat_s, cur_sew_s, cur_op_s);
    fold_s  = fold_step(64'(acc_r), sew_r, fold_cnt_r, op_r);
    seed_s  = elem_op(64'(acc_r), 64'(scalar_r), sew_r, op_r);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          next_state_s = in_last ? FOLD : ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (xfer_s && in_last) begin
          next_state_s = FOLD;
        end else begin
          next_state_s = ACCUM;
        end
      end
      FOLD: begin
        if (fold_cnt_r == 3'd0) begin
          next_state_s = SEED;
        end else begin
          next_state_s = FOLD;
        end
      end
      SEED: next_state_s = DONE;
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ACCUM:   in_ready = 1'b1;
      FOLD:    in_ready = 1'b0;
      SEED:    in_ready = 1'b0;
      DONE:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Accumulator, latched controls, fold counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      scalar_r    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      sew_r       <= 2'd0;
      op_r        <= 3'd0;
      fold_cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            sew_r      <= in_sew_s;
            op_r       <= opSel[2:0];
            acc_r      <= beat_s[DATA_WIDTH-1:0];
            fold_cnt_r <= 3'(MAX_SEW - int'(in_sew_s));
            if (in_last) begin
              scalar_r <= scalar_init;
            end
          end
        end
        ACCUM: begin
          if (xfer_s) begin
            acc_r <= accum_s[DATA_WIDTH-1:0];
            if (in_last) begin
              scalar_r <= scalar_init;
            end
          end
        end
        FOLD: begin
          if (fold_cnt_r != 3'd0) begin
            acc_r      <= fold_s[DATA_WIDTH-1:0];
            fold_cnt_r <= fold_cnt_r - 3'd1;
          end
        end
        SEED: begin
          out_data_r  <= seed_s[DATA_WIDTH-1:0];
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_vred_accum_unit.sv
// Table-driven bench for vred_accum_unit with a result scoreboard and hand-written corner sequences.
module tb_vred_accum_unit;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_MINU = 3'b100;
  localparam logic [2:0] OP_MAXU = 3'b101;
  localparam logic [2:0] OP_MIN  = 3'b110;
  localparam logic [2:0] OP_MAX  = 3'b111;

  typedef struct packed {
    logic [1:0]        sew;
    logic [2:0]        op;
    logic [2:0]        nb;
    logic [2:0][63:0]  d;
    logic [2:0][7:0]   m;
    logic [63:0]       sc;
    logic [63:0]       exp;
  } vec_t;

  logic        clk, rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [63:0] in_data, scalar_init, out_data;
  logic [7:0]  in_mask;
  logic [1:0]  sew;
  logic [2:0]  op_sel;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in_data, b_scalar_init, b_out_data;
  logic [7:0]  b_in_mask;
  logic [1:0]  b_sew;
  logic [2:0]  b_op_sel;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  vec_t        vecs[12];

  vred_accum_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .in_last(in_last), .scalar_init(scalar_init), .sew(sew), .opSel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  vred_accum_unit #(.ENABLE_64_BIT(1'b0)) dut_no64 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mask(b_in_mask), .in_last(b_in_last), .scalar_init(b_scalar_init), .sew(b_sew),
    .opSel(b_op_sel), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic [2:0] o, input logic [2:0] n,
                              input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                              input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                              input logic [63:0] sc, input logic [63:0] ex);
    vec_t v;
    v.sew = s; v.op = o; v.nb = n;
    v.d = {d2, d1, d0};
    v.m = {m2, m1, m0};
    v.sc = sc; v.exp = ex;
    return v;
  endfunction

  // Scoreboard: compare each accepted result against the oldest expected value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", out_data, mon_exp);
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic last,
                           input logic [63:0] sc);
    int n;
    in_data = d; in_mask = m; in_last = last; scalar_init = sc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("in_ready_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    chk(name, lat, exp_lat);
  endtask

  task automatic drain_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("result_wait");
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back(v.exp);
    for (int b = 0; b < int'(v.nb); b++) begin
      // Later beats carry scrambled sew/opSel that must be ignored.
      if (b == 0) begin
        sew = v.sew; op_sel = v.op;
      end else begin
        sew = ~v.sew; op_sel = ~v.op;
      end
      send_beat(v.d[b], v.m[b], (b == int'(v.nb) - 1), v.sc);
    end
    wait_valid(5 - int'(v.sew), "latency");
    drain_idle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 64'd0; in_mask = 8'd0;
    scalar_init = 64'd0; sew = 2'd0; op_sel = 3'd0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = 64'd0; b_in_mask = 8'd0;
    b_scalar_init = 64'd0; b_sew = 2'd0; b_op_sel = 3'd0; b_out_ready = 1'b1;

    vecs[0]  = mk(2'd0, OP_SUM, 3'd1, 64'h0807060504030201, 64'd0, 64'd0, 8'hFF, 8'h00, 8'h00,
                  64'h10, 64'h34);
    vecs[1]  = mk(2'd2, OP_MAX, 3'd2, 64'hFFFFFFF0_00000005, 64'h80000000_00000003, 64'd0,
                  8'hFF, 8'hFF, 8'h00, 64'hFFFFFFFF, 64'h5);
    vecs[2]  = mk(2'd2, OP_MAXU, 3'd2, 64'hFFFFFFF0_00000005, 64'h80000000_00000003, 64'd0,
                  8'hFF, 8'hFF, 8'h00, 64'hFFFFFFFF, 64'hFFFFFFFF);
    vecs[3]  = mk(2'd1, OP_MINU, 3'd2, 64'd0, 64'h1111_1111_1111_1111, 64'd0, 8'h00, 8'h00, 8'h00,
                  64'h1234, 64'h1234);
    vecs[4]  = mk(2'd0, OP_SUM, 3'd3, 64'h0101010101010101, 64'h0202020202020202,
                  64'h0303030303030303, 8'hFF, 8'h0F, 8'hF0, 64'h0, 64'h1C);
    vecs[5]  = mk(2'd3, OP_SUM, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'd0, 8'h01, 8'hFF, 8'h00,
                  64'h0, 64'h1);
    vecs[6]  = mk(2'd0, OP_MIN, 3'd1, 64'h7F80_0102_0304_0506, 64'd0, 64'd0, 8'hFF, 8'h00, 8'h00,
                  64'h0, 64'h80);
    vecs[7]  = mk(2'd1, OP_MIN, 3'd1, 64'h1111_8000_2222_F000, 64'd0, 64'd0, 8'hF5, 8'h00, 8'h00,
                  64'h0005, 64'h8000);
    vecs[8]  = mk(2'd2, OP_MINU, 3'd3, 64'h00000010_00000020, 64'h00000030_00000008,
                  64'h00000001_FFFFFFFF, 8'hFF, 8'hFF, 8'h02, 64'h7, 64'h1);
    vecs[9]  = mk(2'd0, OP_MAXU, 3'd1, 64'h00FF_0000_0000_0000, 64'd0, 64'd0, 8'h3F, 8'h00, 8'h00,
                  64'h3, 64'h3);
    vecs[10] = mk(2'd3, OP_MAX, 3'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 8'h01, 8'h00, 8'h00,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[11] = mk(2'd1, OP_SUM, 3'd1, 64'h0001_0002_0003_0004, 64'd0, 64'd0, 8'h0F, 8'h00, 8'h00,
                  64'hFFFF_FFF0, 64'hFFFA);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 64'd0);

    for (int k = 0; k < 12; k++) run_vec(vecs[k]);

    // Backpressure: result and in_ready must hold while out_ready is low.
    out_ready = 1'b0;
    sew = 2'd0; op_sel = OP_SUM;
    exp_q.push_back(64'hF9);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h01);
    wait_valid(5, "hold_latency");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_out_data", out_data, 64'hF9);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    drain_idle();

    // Reset while folding aborts the reduction at once.
    sew = 2'd0; op_sel = OP_SUM;
    send_beat(64'h0102030405060708, 8'hFF, 1'b1, 64'h0);
    @(posedge clk);
    #1;
    chk("fold_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_fold_out_valid", out_valid, 1'b0);
    chk("abort_fold_busy", busy, 1'b0);
    chk("abort_fold_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(2'd0, OP_SUM, 3'd1, 64'h0101010101010101, 64'd0, 64'd0, 8'hFF, 8'h00, 8'h00,
               64'h0, 64'h08));

    // Reset while holding a result drops out_valid immediately.
    out_ready = 1'b0;
    sew = 2'd3; op_sel = OP_SUM;
    send_beat(64'h5, 8'hFF, 1'b1, 64'h0);
    wait_valid(2, "abort_done_latency");
    rst = 1'b1;
    #1;
    chk("abort_done_out_valid", out_valid, 1'b0);
    chk("abort_done_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_done_out_data", out_data, 64'd0);

    // 64-bit elements disabled: sew=3 behaves as 32-bit elements.
    begin
      int lat;
      @(negedge clk);
      b_in_data = 64'h0000_0001_0000_0002; b_in_mask = 8'hFF; b_in_last = 1'b1;
      b_scalar_init = 64'h0; b_sew = 2'd3; b_op_sel = OP_SUM; b_in_valid = 1'b1;
      chk("no64_in_ready", b_in_ready, 1'b1);
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!b_out_valid && lat < 50);
      chk("no64_latency", lat, 3);
      chk("no64_out_data", b_out_data, 64'h3);
      @(posedge clk);
      #1;
      chk("no64_out_valid_cleared", b_out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vred_accum_unit.md
Name: vred_accum_unit

Overview:
Multi-beat vector reduction engine that generalises the single-pair reduce/min/max block. It accepts a stream of DATA_WIDTH-bit beats of packed SEW elements under a valid/ready handshake, with per-element masks. It accumulates lane-wise across beats, folds the lanes into one element with a log-depth tree over successive cycles, and combines the scalar seed (vs1[0]). It serves vredsum/vredminu/vredmaxu/vredmin/vredmax in the vALU.

Parameters:
DATA_WIDTH, 64, bits per input beat; power of two, 16..64.
SEW_WIDTH, 2, width of sew code (0=8b, 1=16b, 2=32b, 3=64b).
OPSEL_WIDTH, 3, width of opSel.
ENABLE_64_BIT, 1, when 0, sew=3 is treated as sew=2.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  beat valid.
in_ready  out  1  unit can accept a beat.
in_data  in  DATA_WIDTH  packed source elements (vs2).
in_mask  in  DATA_WIDTH/8  element-active bits; bit i applies to element i at the current SEW; bits at or above DATA_WIDTH/SEWbits are ignored.
in_last  in  1  final beat of the reduction.
scalar_init  in  DATA_WIDTH  seed; low SEW bits are used, sampled with the last beat.
sew  in  SEW_WIDTH  element width, sampled on the first accepted beat.
opSel  in  OPSEL_WIDTH  operation, sampled on the first accepted beat. [2]=min/max (0=sum), [1]=signed, [0]=max (1) / min (0).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  DATA_WIDTH  result in low SEW bits, upper bits zero.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE; accumulator, out_data, out_valid, latched sew/opSel and fold counter all 0. in_ready reads 1 immediately after reset.
- States: IDLE, ACCUM, FOLD, SEED, DONE.
- in_ready=1 only in IDLE and ACCUM. A beat transfers when in_valid&&in_ready.
- IDLE: on a transfer, latch sew/opSel, then load acc = masked beat.
  - in_last=0 → ACCUM.
  - in_last=1 → latch scalar_init, go to FOLD.
- Masking: an inactive element is replaced by the identity for the op. Identities: sum 0; maxu 0; minu all-ones; max most-negative; min most-positive.
- ACCUM: on each transfer, acc[lane] = op(acc[lane], masked beat[lane]) for every lane. in_last=1 → latch scalar_init, go to FOLD.
- FOLD: runs log2(DATA_WIDTH/SEWbits) cycles. Each cycle, the low half of the active lanes becomes op(low, high); vacated lanes become identity. When the lane count is 1 (e.g. DATA_WIDTH=SEWbits), skip to SEED with zero fold cycles.
- SEED: out_data = op(acc[0], scalar) zero-extended; assert out_valid; go to DONE.
- DONE: hold out_valid and out_data until out_ready=1. On that cycle deassert out_valid and go to IDLE. A new beat is accepted no earlier than the following cycle.
- Latency, last-beat transfer to out_valid rising: fold cycles + 2 (DATA_WIDTH=64: SEW8 → 5, SEW16 → 4, SEW32 → 3, SEW64 → 2).
- Arithmetic: sum wraps modulo 2^SEW with no saturation or overflow flag. Signed compares use two's complement at SEW. A tie returns the accumulator operand.
- An all-masked reduction returns scalar_init[SEW-1:0].
- sew/opSel changes after the first beat are ignored until the next IDLE.
- rst asserted in any state aborts immediately: partial result discarded, out_valid=0.

Test Plan:
- DATA_WIDTH=64, sew=0, opSel=sum, single beat 0x0807060504030201, mask 0xFF, last=1, scalar 0x10 → out_data=0x34, out_valid 5 cycles after the transfer.
- sew=2, opSel=max signed, beats {0xFFFFFFF0_00000005}, {0x80000000_00000003}, scalar 0xFFFFFFFF → out_data=0x00000005. Repeat with unsigned max → 0xFFFFFFFF.
- sew=1, opSel=minu, mask 0x0 on all beats, scalar 0x1234 → out_data=0x1234.
- sew=0 sum of 8 elements of 0xFF, scalar 0x01 → wraps to 0xF9. Hold out_ready=0 for 4 cycles → out_data stable and in_ready=0 throughout.
- Assert rst during FOLD → out_valid=0 and busy=0 the same cycle. A following sum reduction of 0x01s with scalar 0 gives 0x08 with no stale data.
- ENABLE_64_BIT=0, sew=3, sum of 0x00000001_00000002 with scalar 0 → treated as sew=2, out_data=0x3.
